// File: rtl/fpu_pkg.sv
// Shared opcode encodings, IEEE-754 single field widths and result classification
// for the FPU issue buffer.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam int FLAG_DBZ  = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_NAN  = 3;

  // Division by zero looks at the divisor magnitude only, so -0 also counts.
  function automatic logic [3:0] classify(input logic [EXP_W+MANT_W:0] res,
                                          input logic [1:0]             opcode,
                                          input logic [EXP_W+MANT_W-1:0] op2_mag);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic [3:0]        f;
    e = res[MANT_W +: EXP_W];
    m = res[MANT_W-1:0];
    f = '0;
    f[FLAG_NAN]  = (e == {EXP_W{1'b1}}) && (m != '0);
    f[FLAG_INF]  = (e == {EXP_W{1'b1}}) && (m == '0);
    f[FLAG_ZERO] = (e == '0) && (m == '0);
    f[FLAG_DBZ]  = (opcode == OP_DIV) && (op2_mag == '0);
    return f;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO with wrap-bit pointers; overflowing pushes and
// underflowing pops are ignored. Head entry is visible combinationally.
module fpu_req_fifo #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fpu_issue_buffer.sv
// Queues FPU requests, presents the oldest to the combinational FPU and registers
// its result, tag and classification flags into a valid/ready output stage.
module fpu_issue_buffer
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_op1,
  input  logic [DATA_WIDTH-1:0]   in_op2,
  input  logic [OP_WIDTH-1:0]     in_opcode,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic [DATA_WIDTH-1:0]   fpu_op1,
  output logic [DATA_WIDTH-1:0]   fpu_op2,
  output logic [OP_WIDTH-1:0]     fpu_opcode,
  input  logic [DATA_WIDTH-1:0]   fpu_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [3:0]              out_flags,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int REQ_W = 2*DATA_WIDTH + OP_WIDTH + TAG_WIDTH;

  logic [REQ_W-1:0]      head;
  logic                  full, empty, push, load;
  logic [DATA_WIDTH-1:0] head_op1, head_op2;
  logic [OP_WIDTH-1:0]   head_opc;
  logic [TAG_WIDTH-1:0]  head_tag;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [3:0]            out_flags_q, out_flags_d;

  assign push = in_valid && !full;
  assign load = !empty && (!out_valid_q || out_ready);

  fpu_req_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({in_op1, in_op2, in_opcode, in_tag}),
    .pop_i   (load),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  assign {head_op1, head_op2, head_opc, head_tag} = head;

  // Idle FPU inputs are zeroed so the FPU never sees stale storage.
  assign fpu_op1    = empty ? '0 : head_op1;
  assign fpu_op2    = empty ? '0 : head_op2;
  assign fpu_opcode = empty ? '0 : head_opc;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_flags_d  = out_flags_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_result_d = fpu_result;
      out_tag_d    = head_tag;
      out_flags_d  = classify(fpu_result, head_opc, head_op2[DATA_WIDTH-2:0]);
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign in_ready   = !full;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fpu_issue_buffer.sv
// Directed bench for fpu_issue_buffer with an FPU stub and an in-order result scoreboard.
module tb_fpu_issue_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_op1, in_op2;
  logic [1:0]    in_opcode;
  logic [3:0]    in_tag;
  logic [DW-1:0] fpu_op1, fpu_op2;
  logic [1:0]    fpu_opcode;
  logic [DW-1:0] fpu_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [3:0]    out_tag;
  logic [3:0]    out_flags;
  logic [2:0]    occupancy;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_in   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fpu_issue_buffer #(.DATA_WIDTH(32), .OP_WIDTH(2), .TAG_WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_opcode(in_opcode), .in_tag(in_tag),
    .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_opcode(fpu_opcode),
    .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags),
    .occupancy(occupancy)
  );

  // FPU stub: exact answers for the directed IEEE vectors, a cheap mixing function otherwise.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] opc);
    if (opc == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (opc == 2'b01 && a == 32'h40000000 && b == 32'h40000000) return 32'h00000000;
    if (opc == 2'b11 && a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {30'd0, opc};
  endfunction

  function automatic logic [3:0] exp_flags(input logic [31:0] r, input logic [1:0] opc,
                                           input logic [31:0] b);
    logic nan, inf, zero, dbz;
    nan  = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    inf  = (r[30:23] == 8'hFF) && (r[22:0] == 0);
    zero = (r[30:0] == 0);
    dbz  = (opc == 2'b11) && (b[30:0] == 0);
    return {nan, inf, zero, dbz};
  endfunction

  always_comb fpu_result = fpu_model(fpu_op1, fpu_op2, fpu_opcode);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes are decided by values stable across the low phase.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", {32'd0, out_result}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_result", {32'd0, out_result}, {32'd0, e.res});
          check("sb_tag", {60'd0, out_tag}, {60'd0, e.tag});
          check("sb_flags", {60'd0, out_flags}, {60'd0, e.flags});
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        n_in++;
        e.res   = fpu_model(in_op1, in_op2, in_opcode);
        e.tag   = in_tag;
        e.flags = exp_flags(e.res, in_opcode, in_op2);
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc,
                       input logic [3:0] tag);
    in_valid  = 1'b1;
    in_op1    = a;
    in_op2    = b;
    in_opcode = opc;
    in_tag    = tag;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      step();
      n++;
    end
    check("drain_timeout", {63'd0, (n >= 60)}, 64'd0);
  endtask

  logic [31:0] held;
  int acc;
  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op1 = '0; in_op2 = '0; in_opcode = '0; in_tag = '0;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_tag_flags", {56'd0, out_tag, out_flags}, 64'd0);
    check("rst_occupancy", {61'd0, occupancy}, 64'd0);
    check("idle_fpu_inputs", {fpu_op1, fpu_op2}, 64'd0);

    // Single add and its two-cycle latency.
    drive(32'h3F800000, 32'h40000000, 2'b00, 4'd3);
    step();
    in_valid = 1'b0;
    check("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    check("lat_occ1", {61'd0, occupancy}, 64'd1);
    step();
    check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    check("add_result", {32'd0, out_result}, 64'h40400000);
    check("add_tag", {60'd0, out_tag}, 64'd3);
    check("add_flags", {60'd0, out_flags}, 64'd0);
    drain();

    // Eight back-to-back requests with no bubbles.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        drive($urandom, $urandom, 2'(c), 4'(c + 8));
        check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      check("stream_out_valid", {63'd0, out_valid}, {63'd0, (c >= 2)});
      step();
    end
    drain();

    // Output stall: DEPTH+1 requests held, then in_ready drops.
    out_ready = 1'b0;
    acc = 0;
    held = '0;
    for (int i = 0; i < 8; i++) begin
      if (!in_ready) break;
      drive($urandom, $urandom, 2'(i), 4'(i));
      acc++;
      step();
      if (i == 1) held = out_result;
    end
    in_valid = 1'b0;
    check("stall_accepted", acc, 5);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    check("stall_occupancy", {61'd0, occupancy}, 64'd4);
    check("stall_hold", {32'd0, out_result}, {32'd0, held});
    drive(32'h1, 32'h2, 2'b00, 4'hF);
    step();
    in_valid = 1'b0;
    check("full_no_write", {61'd0, occupancy}, 64'd4);
    drain();

    // Division by zero and exact-zero subtraction flags.
    drive(32'h3F800000, 32'h00000000, 2'b11, 4'd5);
    step();
    drive(32'h40000000, 32'h40000000, 2'b01, 4'd6);
    step();
    in_valid = 1'b0;
    check("div_flags", {60'd0, out_flags}, 64'b0101);
    step();
    check("sub_flags", {60'd0, out_flags}, 64'b0010);
    drain();

    // Simultaneous push and pop at occupancy 2.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 2'b10, 4'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    check("pp_pre_occ", {61'd0, occupancy}, 64'd2);
    drive($urandom, $urandom, 2'b00, 4'd9);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("pp_occ", {61'd0, occupancy}, 64'd2);
    drain();

    // Pointer wrap with random handshakes.
    base = n_out;
    acc = 0;
    for (int c = 0; c < 300 && acc < 3 * DEPTH; c++) begin
      out_ready = 1'($urandom);
      if ($urandom_range(3) != 0) begin
        drive($urandom, $urandom, 2'($urandom), 4'(acc));
        if (in_ready) acc++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    drain();
    check("wrap_count", n_out - base, 3 * DEPTH);

    // Reset while holding a result and three queued requests.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive($urandom, $urandom, 2'b00, 4'(i));
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_occ", {61'd0, occupancy}, 64'd3);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_occ", {61'd0, occupancy}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 6; i++) step();
    check("no_stale_result", n_out - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_buffer.md
# fpu_issue_buffer

Sequential front/back end for the combinational floating-point unit. It accepts operand/opcode requests over a valid/ready handshake and buffers them in a small FIFO. It presents the oldest request to the FPU and registers the FPU result, with a tag and IEEE-754 classification flags, into an output stage with its own valid/ready handshake. It sits directly upstream of the FPU, feeding its operand and opcode inputs, and directly downstream of it, consuming its result output.

## Interface
- DATA_WIDTH, 32, operand/result width (IEEE-754 single precision)
- OP_WIDTH, 2, opcode width
- TAG_WIDTH, 4, request tag width, returned unchanged with the result
- DEPTH, 4, request FIFO entries; power of 2, ≥2

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  buffer can accept; equals !full
- in_op1, in_op2  in  DATA_WIDTH  operands
- in_opcode  in  OP_WIDTH  00 add, 01 sub, 10 mul, 11 div
- in_tag  in  TAG_WIDTH  request tag
- fpu_op1, fpu_op2  out  DATA_WIDTH  head-of-FIFO operands to FPU (0 when empty)
- fpu_opcode  out  OP_WIDTH  head opcode to FPU (0 when empty)
- fpu_result  in  DATA_WIDTH  combinational FPU result for current fpu_* inputs
- out_valid  out  1  result register holds valid data
- out_ready  in  1  consumer accepts result
- out_result  out  DATA_WIDTH  registered result
- out_tag  out  TAG_WIDTH  tag of registered result
- out_flags  out  4  {nan, inf, zero, div_by_zero}
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count

## Operation
- Push: in_valid && in_ready at an edge writes {op1, op2, opcode, tag} at wr_ptr; wr_ptr increments modulo DEPTH.
- Load: when count>0 && (!out_valid || out_ready), the edge captures fpu_result, the head tag and flags into the output register, sets out_valid and pops the head (rd_ptr++ mod DEPTH).
- Drain: out_valid && out_ready && count==0 clears out_valid at the edge.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full: in_ready=0, no write, no fall-through. Empty: no load; fpu_* inputs driven to 0.
- Ordering: strictly FIFO; results leave in request order.
- Flags, evaluated on the captured result:
  - nan: exp==8'hFF && mant!=0
  - inf: exp==8'hFF && mant==0
  - zero: exp==0 && mant==0, either sign
  - div_by_zero: head opcode==11 && op2[30:0]==0
- out_result, out_tag and out_flags hold while out_valid && !out_ready.
- Pointers carry one extra wrap bit; full = MSBs differ and the low bits are equal.
- occupancy = count, 0..DEPTH.

## Timing
- Reset: in_ready=1, out_valid=0, out_result=0, out_tag=0, out_flags=0, occupancy=0, pointers 0, FIFO contents don't-care. rst mid-operation discards all queued and held results at that edge.
- Latency: request accepted at edge N is in the FIFO during cycle N+1, captured at edge N+1, and has out_valid high in cycle N+2. Minimum 2 cycles.
- Throughput: one request per cycle sustained while out_ready=1; no bubbles.
- The FPU path from fpu_* through fpu_result is combinational within one cycle. No FPU timing assumptions beyond that.
- Back-pressure: with out_ready=0, the FIFO fills. in_ready drops in the cycle after the DEPTH-th accept counted from the output stall (DEPTH+1 requests held in total).
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.

## Structure
- Shared package fpu_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - field widths EXP_W=8, MANT_W=23
  - flag bit indices
  - classify function returning the 4-bit flag vector
- Sub-module fpu_req_fifo: parameterised synchronous FIFO (DATA_WIDTH*2+OP_WIDTH+TAG_WIDTH wide) with push/pop/full/empty/count.
- fpu_issue_buffer holds the FIFO instance, the output register and the handshake logic; it contains no arithmetic.

## Test plan
- Reset then single add: 3F800000 + 40000000, tag 3 -> out_valid 2 cycles after accept; out_result=40400000, tag=3, flags=0000.
- Stream 8 back-to-back mixed ops, out_ready=1 -> in_ready stays 1; 8 results on consecutive cycles, in order, tags match.
- out_ready=0, DEPTH=4, push until stall -> 5 accepted, in_ready=0, occupancy=4, out_result stable. Raising out_ready drains all 5 in order.
- Div 3F800000 / 00000000 (opcode 11) -> out_flags div_by_zero=1 and inf=1. Sub 40000000 - 40000000 -> zero=1.
- Push and pop in the same cycle at occupancy 2 -> occupancy stays 2. Wrap test: 3×DEPTH requests with random out_ready -> no loss or duplication.
- rst asserted for one cycle with occupancy=3 and out_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, and no stale result appears afterwards.
